mul_int_iter: RTL and testbench

Parametrised iterative integer multiplier: one radix-4 Booth step per clock, trading throughput for area against the fixed-width pipelined multiplier. Sits behind a valid/ready handshake on both sides and serves ALUs or DSP sequencers where a low-area `WIDTH x WIDTH -> 2*WIDTH` multiply with unsigned, mixed and signed modes is needed. Adds backpressure, synchronous abort and width generality.

---
 rtl/mul_int_pkg.sv | 22 ++
 rtl/booth_radix4.sv | 34 +++
 rtl/mul_int_iter.sv | 108 ++++++++++
 tb/tb_mul_int_iter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_int_pkg.sv
// Shared opcode and FSM state encodings for the iterative integer multiplier.
package mul_int_pkg;

  typedef enum logic [1:0] {
    UNSIGNED_X_UNSIGNED = 2'b00,
    SIGNED_X_UNSIGNED   = 2'b01,
    SIGNED_X_SIGNED     = 2'b10,
    OPCODE_RESERVED     = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  // Radix-4 digits needed to cover a multiplier extended to width+2 bits.
  function automatic int booth_digits(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_radix4.sv
// Radix-4 Booth partial-product select: {0, +-A, +-2A}; negation is
// one's complement here with the +1 returned on carry for the adder.
module booth_radix4 #(
  parameter int W = 130
) (
  input  logic [2:0]   digit,
  input  logic [W-1:0] a,
  output logic [W-1:0] pp,
  output logic         carry
);

  logic [W-1:0] mag;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    mag   = '0;
    carry = 1'b0;
    case (digit)
      3'b001, 3'b010: mag = a;
      3'b011:         mag = {a[W-2:0], 1'b0};
      3'b100: begin
        mag   = {a[W-2:0], 1'b0};
        carry = 1'b1;
      end
      3'b101, 3'b110: begin
        mag   = a;
        carry = 1'b1;
      end
      default: mag = '0;
    endcase
    pp = carry ? ~mag : mag;
  end

endmodule

// File: rtl/mul_int_iter.sv
// Iterative WIDTH x WIDTH -> 2*WIDTH multiplier, one radix-4 Booth step per
// clock, valid/ready on both sides, synchronous flush.
module mul_int_iter
  import mul_int_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       opcode,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo
);

  localparam int N  = booth_digits(WIDTH);
  localparam int CW = $clog2(N);
  localparam int AW = 2 * WIDTH + 2;
  localparam int BW = WIDTH + 3;  // extended multiplier plus the implicit bit -1

  state_e        state, state_next;
  logic [CW-1:0] count;
  logic [AW-1:0] mcand, acc, pp, acc_next, a_ext;
  logic [BW-1:0] mplier, b_ext;
  logic          neg, accept, last;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready && !flush;
  assign last      = (count == CW'(N - 1));

  // Operand extension per opcode; the reserved opcode zeroes A so the product is 0.
  always_comb begin
    a_ext = '0;
    b_ext = {2'b00, multiplier, 1'b0};
    case (opcode_e'(opcode))
      UNSIGNED_X_UNSIGNED: a_ext = {{(AW - WIDTH){1'b0}}, multiplicand};
      SIGNED_X_UNSIGNED:   a_ext = {{(AW - WIDTH){multiplicand[WIDTH-1]}}, multiplicand};
      SIGNED_X_SIGNED: begin
        a_ext = {{(AW - WIDTH){multiplicand[WIDTH-1]}}, multiplicand};
        b_ext = {{2{multiplier[WIDTH-1]}}, multiplier, 1'b0};
      end
      default: a_ext = '0;
    endcase
  end

  booth_radix4 #(.W(AW)) u_booth (
    .digit (mplier[2:0]),
    .a     (mcand),
    .pp    (pp),
    .carry (neg)
  );

  assign acc_next = acc + pp + AW'(neg);

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_next = BUSY;
        BUSY:    if (last)     state_next = DONE;
        DONE:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // The multiplicand walks left by 2 and the multiplier right by 2 each step,
  // so the digit and its 2i shift always sit at the low end of the registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count     <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      result_hi <= '0;
      result_lo <= '0;
    end else if (accept) begin
      count  <= '0;
      acc    <= '0;
      mcand  <= a_ext;
      mplier <= b_ext;
    end else if (state == BUSY && !flush) begin
      count  <= count + CW'(1);
      acc    <= acc_next;
      mcand  <= mcand << 2;
      mplier <= mplier >> 2;
      if (last) {result_hi, result_lo} <= acc_next[2*WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_mul_int_iter.sv
// Scoreboard bench: a 64-bit instance for directed vectors, handshake and
// flush cases; a 16-bit instance for async reset and a randomised sweep.
module tb_mul_int_iter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // 64-bit instance
  logic        big_reset, big_flush, big_in_valid, big_in_ready, big_busy;
  logic        big_out_valid, big_out_ready;
  logic [1:0]  big_opcode;
  logic [63:0] big_a, big_b, big_hi, big_lo;

  // 16-bit instance
  logic        small_reset, small_flush, small_in_valid, small_in_ready, small_busy;
  logic        small_out_valid, small_out_ready;
  logic [1:0]  small_opcode;
  logic [15:0] small_a, small_b, small_hi, small_lo;

  mul_int_iter #(.WIDTH(64)) u_big (
    .clock(clock), .reset(big_reset), .flush(big_flush),
    .in_valid(big_in_valid), .in_ready(big_in_ready), .opcode(big_opcode),
    .multiplicand(big_a), .multiplier(big_b), .busy(big_busy),
    .out_valid(big_out_valid), .out_ready(big_out_ready),
    .result_hi(big_hi), .result_lo(big_lo)
  );

  mul_int_iter #(.WIDTH(16)) u_small (
    .clock(clock), .reset(small_reset), .flush(small_flush),
    .in_valid(small_in_valid), .in_ready(small_in_ready), .opcode(small_opcode),
    .multiplicand(small_a), .multiplier(small_b), .busy(small_busy),
    .out_valid(small_out_valid), .out_ready(small_out_ready),
    .result_hi(small_hi), .result_lo(small_lo)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
  endtask

  logic [127:0] exp_big_q[$];
  logic [31:0]  exp_small_q[$];
  logic [127:0] e_big;
  logic [31:0]  e_small;

  // Monitors: a handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clock) begin
    if (big_out_valid && big_out_ready) begin
      if (exp_big_q.size() == 0) check("big_unexpected_result", 128'(1), 128'(0));
      else begin
        e_big = exp_big_q.pop_front();
        check("big_result", {big_hi, big_lo}, e_big);
      end
    end
    if (small_out_valid && small_out_ready) begin
      if (exp_small_q.size() == 0) check("small_unexpected_result", 128'(1), 128'(0));
      else begin
        e_small = exp_small_q.pop_front();
        check("small_result", 128'({small_hi, small_lo}), 128'(e_small));
      end
    end
  end

  logic sweep_on = 1'b0;
  initial begin
    small_out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      small_out_ready = sweep_on ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] ref16(input logic [1:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [31:0] ea, eb;
    ea = (op == 2'b01 || op == 2'b10) ? {{16{a[15]}}, a} : {16'h0, a};
    eb = (op == 2'b10) ? {{16{b[15]}}, b} : {16'h0, b};
    return (op == 2'b11) ? 32'h0 : ea * eb;
  endfunction

  // All stimulus tasks are entered and left 1 time unit after a rising edge.
  task automatic issue_big(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    int waited = 0;
    big_opcode = op; big_a = a; big_b = b; big_in_valid = 1'b1;
    while (!big_in_ready && waited < 100) begin
      @(posedge clock); #1; waited++;
    end
    if (!big_in_ready) check("big_in_ready_timeout", 128'(0), 128'(1));
    @(posedge clock); #1;
    big_in_valid = 1'b0;
    big_opcode   = 2'($urandom());
    big_a        = {$urandom(), $urandom()};
    big_b        = {$urandom(), $urandom()};
  endtask

  task automatic wait_big(output int lat);
    lat = 0;
    while (!big_out_valid && lat < 200) begin
      @(posedge clock); #1; lat++;
    end
  endtask

  task automatic issue_small(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    int waited = 0;
    small_opcode = op; small_a = a; small_b = b; small_in_valid = 1'b1;
    while (!small_in_ready && waited < 100) begin
      @(posedge clock); #1; waited++;
    end
    if (!small_in_ready) check("small_in_ready_timeout", 128'(0), 128'(1));
    @(posedge clock); #1;
    small_in_valid = 1'b0;
    small_opcode   = 2'($urandom());
    small_a        = 16'($urandom());
    small_b        = 16'($urandom());
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a, b, hi, lo;
  } vec_t;

  vec_t        vecs[9];
  logic [15:0] corners[5];
  int          lat, waited;
  logic        ov_seen;
  logic [1:0]  op16;
  logic [15:0] a16, b16;

  initial begin
    vecs[0] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFE, 64'h1};
    vecs[1] = '{2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                64'h4000_0000_0000_0000, 64'h0};
    vecs[2] = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h1};
    vecs[3] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFF, 64'h1};
    vecs[4] = '{2'b11, 64'hDEAD_BEEF_1234_5678, 64'hCAFE_F00D_8765_4321, 64'h0, 64'h0};
    vecs[5] = '{2'b00, 64'h1_0000_0000, 64'h1_0000_0000, 64'h1, 64'h0};
    vecs[6] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 64'h3,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA};
    vecs[7] = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFD, 64'h7,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[8] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

    big_reset = 1'b1; big_flush = 1'b0; big_in_valid = 1'b0; big_out_ready = 1'b1;
    big_opcode = 2'b00; big_a = '0; big_b = '0;
    small_reset = 1'b1; small_flush = 1'b0; small_in_valid = 1'b0;
    small_opcode = 2'b00; small_a = '0; small_b = '0;
    #2;
    check("big_reset_flags", 128'({big_in_ready, big_busy, big_out_valid}), 128'(3'b100));
    check("big_reset_result", {big_hi, big_lo}, 128'(0));
    check("small_reset_flags", 128'({small_in_ready, small_busy, small_out_valid}), 128'(3'b100));
    check("small_reset_result", 128'({small_hi, small_lo}), 128'(0));
    @(posedge clock); #1;
    big_reset = 1'b0; small_reset = 1'b0;

    // Directed vectors, each with the latency to first out_valid
    for (int i = 0; i < 9; i++) begin
      exp_big_q.push_back({vecs[i].hi, vecs[i].lo});
      issue_big(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_big(lat);
      check("big_latency", 128'(lat), 128'(33));
      @(posedge clock); #1;
    end

    // Backpressure: result held for 10 cycles, then a single-cycle accept
    big_out_ready = 1'b0;
    exp_big_q.push_back({64'h0, 64'h1_2340});
    issue_big(2'b00, 64'h1234, 64'h10);
    wait_big(lat);
    check("bp_latency", 128'(lat), 128'(33));
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_result", {big_hi, big_lo}, {64'h0, 64'h1_2340});
      check("bp_hold_flags", 128'({big_out_valid, big_in_ready}), 128'(2'b10));
      @(posedge clock); #1;
    end
    big_out_ready = 1'b1;
    @(posedge clock); #1;
    big_out_ready = 1'b0;
    check("bp_release_flags", 128'({big_out_valid, big_in_ready}), 128'(2'b01));
    big_out_ready = 1'b1;

    // Flush in step 5 of BUSY
    issue_big(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (4) begin @(posedge clock); #1; end
    check("flush_pre_busy", 128'(big_busy), 128'(1));
    big_flush = 1'b1;
    @(posedge clock); #1;
    big_flush = 1'b0;
    check("flush_flags", 128'({big_busy, big_in_ready, big_out_valid}), 128'(3'b010));
    ov_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ov_seen |= big_out_valid;
      @(posedge clock); #1;
    end
    check("flush_no_valid", 128'(ov_seen), 128'(0));
    exp_big_q.push_back({64'h0, 64'd15});
    issue_big(2'b00, 64'd3, 64'd5);
    wait_big(lat);
    check("post_flush_latency", 128'(lat), 128'(33));
    @(posedge clock); #1;

    // Flush together with in_valid in IDLE must not accept
    big_opcode = 2'b00; big_a = 64'd7; big_b = 64'd9;
    big_in_valid = 1'b1; big_flush = 1'b1;
    @(posedge clock); #1;
    big_in_valid = 1'b0; big_flush = 1'b0;
    check("flush_idle_flags", 128'({big_busy, big_in_ready}), 128'(2'b01));
    ov_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ov_seen |= big_out_valid;
      @(posedge clock); #1;
    end
    check("flush_idle_no_valid", 128'(ov_seen), 128'(0));

    // 16-bit: one product, then async reset mid-BUSY clears it
    exp_small_q.push_back(32'hFFFE_0001);
    issue_small(2'b00, 16'hFFFF, 16'hFFFF);
    lat = 0;
    while (!small_out_valid && lat < 100) begin
      @(posedge clock); #1; lat++;
    end
    check("small_latency", 128'(lat), 128'(9));
    @(posedge clock); #1;
    issue_small(2'b10, 16'h7FFF, 16'h7FFF);
    repeat (3) @(posedge clock);
    #3;
    small_reset = 1'b1;
    #1;
    check("async_reset_flags", 128'({small_in_ready, small_busy, small_out_valid}), 128'(3'b100));
    check("async_reset_result", 128'({small_hi, small_lo}), 128'(0));
    @(posedge clock); #1;
    small_reset = 1'b0;

    // Random sweep with random out_ready stalls
    sweep_on = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      op16 = 2'($urandom_range(0, 3));
      a16  = (i % 7 == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom());
      b16  = (i % 5 == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom());
      exp_small_q.push_back(ref16(op16, a16, b16));
      issue_small(op16, a16, b16);
    end
    waited = 0;
    while ((exp_small_q.size() != 0 || exp_big_q.size() != 0) && waited < 300) begin
      @(posedge clock); #1; waited++;
    end
    sweep_on = 1'b0;
    check("small_queue_drained", 128'(exp_small_q.size()), 128'(0));
    check("big_queue_drained", 128'(exp_big_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
